// File: rtl/ifetch_queue.sv
// Instruction fetch queue: in-order buffer of {pc, instr} pairs between fetch and decode.
// Optional same-cycle empty-queue bypass is compiled in only when IFQ_BYPASS_EN is defined.
module ifetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_instr,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    input  logic        flush,
    output logic [3:0]  count
);
    localparam int         PTR_W   = $clog2(DEPTH);
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] instr_mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [3:0]       count_q, count_d;

    logic stored_valid;
    logic bypass_hit;
    logic push;
    logic pop;
    logic store_en;
    logic pop_mem;

    assign stored_valid = (count_q != 4'd0);

`ifdef IFQ_BYPASS_EN
    assign bypass_hit = (count_q == 4'd0) && in_valid && !flush && !reset;
`else
    assign bypass_hit = 1'b0;
`endif

    assign in_ready  = (count_q != DEPTH_C);
    assign out_valid = !reset && (stored_valid || bypass_hit);
    assign count     = count_q;

    always_comb begin
        out_pc    = 32'h0000_0000;
        out_instr = 32'h0000_0000;
        if (!reset && stored_valid) begin
            out_pc    = pc_mem[rd_ptr_q];
            out_instr = instr_mem[rd_ptr_q];
        end
`ifdef IFQ_BYPASS_EN
        else if (bypass_hit) begin
            out_pc    = in_pc;
            out_instr = in_instr;
        end
`endif
    end

    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    // A bypassed entry consumed in the same cycle never touches storage.
    assign store_en = push && !(bypass_hit && out_ready);
    assign pop_mem  = pop && stored_valid;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = 4'd0;
        end else begin
            if (store_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_mem)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + {3'b000, store_en} - {3'b000, pop_mem};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= 4'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never cleared; the output mux hides stale contents.
    always_ff @(posedge clk) begin
        if (store_en && !flush && !reset) begin
            pc_mem[wr_ptr_q]    <= in_pc;
            instr_mem[wr_ptr_q] <= in_instr;
        end
    end
endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queued fetch entries; legal values are 2, 4 and 8.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  fetch stage presents a fetched instruction this cycle.
REQ-005 SHALL have port in_pc  input  32  address of the presented instruction, taken from the PC register output.
REQ-006 SHALL have port in_instr  input  32  instruction word read from instruction memory at in_pc.
REQ-007 SHALL have port in_ready  output  1  queue accepts a push this cycle; drives the PC register's enable.
REQ-008 SHALL have port out_valid  output  1  head entry available to decode.
REQ-009 SHALL have port out_ready  input  1  decode consumes the head entry this cycle.
REQ-010 SHALL have port out_pc  output  32  PC of head entry.
REQ-011 SHALL have port out_instr  output  32  instruction word of head entry.
REQ-012 SHALL have port flush  input  1  discard all queued entries (branch/jump redirect).
REQ-013 SHALL have port count  output  4  number of valid entries, 0..DEPTH.

Function
REQ-014 SHALL accept a push exactly when in_valid=1 and in_ready=1.
REQ-015 SHALL pop exactly when out_valid=1 and out_ready=1.
REQ-016 SHALL drive in_ready = (count != DEPTH) combinationally from state only; it SHALL NOT depend on out_ready in the same cycle.
REQ-017 SHALL drive out_valid = (count != 0) when the bypass feature is absent.
REQ-018 SHALL present out_pc/out_instr from the head storage entry; when out_valid=0, they SHALL be 32'h0000_0000.
REQ-019 SHALL deliver entries strictly in push order; an entry pushed at edge N SHALL be visible at the output from cycle N+1 at the earliest.
REQ-020 SHALL, on a simultaneous push and pop, keep count unchanged and advance both pointers.
REQ-021 SHALL use log2(DEPTH)-bit read and write pointers that wrap from DEPTH-1 to 0 with no skipped or duplicated entry.
REQ-022 SHALL, when full, ignore in_valid; instructions presented with in_ready=0 SHALL NOT be stored, and the PC SHALL hold because in_ready is low.
REQ-023 SHALL, when empty, ignore out_ready; count SHALL NOT underflow.
REQ-024 SHALL, on flush=1, set count, read pointer and write pointer to 0 at the next edge; any push or pop in that cycle SHALL be discarded.
REQ-025 SHALL give reset priority over flush, and flush priority over push and pop.

Reset
REQ-026 SHALL, on reset=1 at a rising edge, set count=0, both pointers=0 and out_valid=0, and leave in_ready=1 from the following cycle.
REQ-027 SHALL produce out_pc=0 and out_instr=0 while reset is asserted and until the first push; storage contents need not be cleared.
REQ-028 SHALL discard entries in flight when reset is asserted mid-stream, and SHALL lose no entry pushed after reset deasserts.

Configuration
REQ-029 SHALL compile a same-cycle bypass path only when macro IFQ_BYPASS_EN is defined.
REQ-030 SHALL, with IFQ_BYPASS_EN defined, when count=0 and in_valid=1 and flush=0, drive out_valid=1 with out_pc=in_pc and out_instr=in_instr in the same cycle; if out_ready=1, the entry SHALL NOT be stored and count SHALL stay 0.
REQ-031 SHALL, without IFQ_BYPASS_EN, have a minimum push-to-output latency of exactly one cycle, with no combinational path from the in_* ports to the out_* ports.

Verification
REQ-032 SHALL pass this scenario: reset 2 cycles -> count=0, out_valid=0, in_ready=1, out_pc=0.
REQ-033 SHALL pass this scenario: out_ready=0, push 0x3000/0x3004/0x3008/0x300C (DEPTH=4) -> count=4, in_ready=0; a fifth push of 0x3010 is dropped; draining yields 0x3000..0x300C in order.
REQ-034 SHALL pass this scenario: count=2, push 0x3020 and pop in the same cycle -> count stays 2, the head advances, and 0x3020 becomes the tail.
REQ-035 SHALL pass this scenario: 10 back-to-back pushes 0x3000..0x3024 with out_ready=1 continuously -> all 10 are popped in order, and the pointers wrap twice without loss.
REQ-036 SHALL pass this scenario: count=3 with flush=1 and in_valid=1 (0x3040) -> count=0 next cycle, and 0x3040 is never output.
REQ-037 SHALL pass this scenario: with IFQ_BYPASS_EN, empty, push 0x3000 and out_ready=1 -> out_valid=1 and out_pc=0x3000 in the same cycle, and count stays 0; without the macro, out_valid rises in the next cycle.
